// File: rtl/diagonal_pkg.sv
// Shared definitions for the diagonal walker and its checker: default widths,
// checker state encoding and the single walker step function diag_next.
package diagonal_pkg;

  localparam int unsigned DIAG_MAXW = 16;
  localparam int unsigned W_DEF     = 4;
  localparam int unsigned KMAX_DEF  = (1 << W_DEF) - 1;
  localparam int unsigned CW_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAIL  = 2'd2
  } state_e;

  // Operates on DIAG_MAXW-wide operands; kmax is the all-ones mask of the real width,
  // so every result wraps modulo kmax+1.
  function automatic logic [2*DIAG_MAXW-1:0] diag_next(
    input logic [DIAG_MAXW-1:0] x,
    input logic [DIAG_MAXW-1:0] y,
    input logic [DIAG_MAXW-1:0] kmax
  );
    logic [DIAG_MAXW-1:0] nx;
    logic [DIAG_MAXW-1:0] ny;
    if (x > y) begin
      nx = ((kmax >> 1) + (x >> 1)) & kmax;
      ny = y;
    end else if (x < y) begin
      nx = x;
      ny = (y + DIAG_MAXW'(1)) & kmax;
    end else begin
      nx = (x + DIAG_MAXW'(1)) & kmax;
      ny = (y + DIAG_MAXW'(1)) & kmax;
    end
    return {nx, ny};
  endfunction

endpackage

// File: rtl/diagonal_checker_step_model.sv
// Combinational walker step (x,y)->(x',y') built on diagonal_pkg::diag_next so the
// walker and the checker share one step definition.
module diag_step_model
  import diagonal_pkg::*;
#(
  parameter int unsigned W    = W_DEF,
  parameter int unsigned KMAX = (1 << W) - 1
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] nx,
  output logic [W-1:0] ny
);

  logic [2*DIAG_MAXW-1:0] nxt;

  assign nxt = diag_next(DIAG_MAXW'(x), DIAG_MAXW'(y), DIAG_MAXW'(KMAX));
  assign nx  = W'(nxt[2*DIAG_MAXW-1:DIAG_MAXW]);
  assign ny  = W'(nxt[DIAG_MAXW-1:0]);

endmodule

// File: rtl/diagonal_checker.sv
// Trajectory checker for the diagonal (X,Y) walker: predicts each next sample from the
// last accepted one and raises sticky error flags. Define DIAG_CHK_ASSERT_EN for assertions.
module diagonal_checker
  import diagonal_pkg::*;
#(
  parameter int unsigned W    = W_DEF,
  parameter int unsigned KMAX = (1 << W) - 1,
  parameter int unsigned CW   = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_x,
  input  logic [W-1:0]  in_y,
  output logic          err_order,
  output logic          err_step,
  output logic          fail,
  output logic [CW-1:0] steps
);

  localparam logic [W-1:0]  INIT_X    = W'(1);
  localparam logic [W-1:0]  INIT_Y    = '0;
  localparam logic [CW-1:0] STEPS_MAX = '1;

  state_e        state_q, state_d;
  logic          err_order_q, err_order_d;
  logic          err_step_q, err_step_d;
  logic [CW-1:0] steps_q, steps_d;
  logic [W-1:0]  prev_x_q, prev_x_d;
  logic [W-1:0]  prev_y_q, prev_y_d;
  logic [W-1:0]  exp_x, exp_y;
  logic          accept;
  logic          step_bad;
  logic          order_bad;

  diag_step_model #(.W(W), .KMAX(KMAX)) u_step (
    .x  (prev_x_q),
    .y  (prev_y_q),
    .nx (exp_x),
    .ny (exp_y)
  );

  assign in_ready = (state_q != FAIL) && !reset;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    err_order_d = err_order_q;
    err_step_d  = err_step_q;
    steps_d     = steps_q;
    prev_x_d    = prev_x_q;
    prev_y_d    = prev_y_q;
    step_bad    = 1'b0;
    order_bad   = 1'b0;
    if (accept) begin
      // The first sample after reset must be the walker's init point, not a predicted step.
      case (state_q)
        IDLE:    step_bad = (in_x != INIT_X) || (in_y != INIT_Y);
        TRACK: begin
          step_bad  = (in_x != exp_x) || (in_y != exp_y);
          order_bad = in_x < in_y;
        end
        default: ;
      endcase
      prev_x_d    = in_x;
      prev_y_d    = in_y;
      steps_d     = (steps_q == STEPS_MAX) ? steps_q : steps_q + CW'(1);
      err_step_d  = err_step_q | step_bad;
      err_order_d = err_order_q | order_bad;
      state_d     = (step_bad || order_bad) ? FAIL : TRACK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      err_order_q <= 1'b0;
      err_step_q  <= 1'b0;
      steps_q     <= '0;
      prev_x_q    <= INIT_X;
      prev_y_q    <= INIT_Y;
    end else begin
      state_q     <= state_d;
      err_order_q <= err_order_d;
      err_step_q  <= err_step_d;
      steps_q     <= steps_d;
      prev_x_q    <= prev_x_d;
      prev_y_q    <= prev_y_d;
    end
  end

  assign err_order = err_order_q;
  assign err_step  = err_step_q;
  assign fail      = err_order_q | err_step_q;
  assign steps     = steps_q;

`ifdef DIAG_CHK_ASSERT_EN
  a_no_fail: assert property (@(posedge clk) disable iff (reset) !fail);
  a_order:   assert property (@(posedge clk) disable iff (reset)
                              !(in_valid && in_ready && (in_x < in_y)));
`else
`endif

endmodule
